// File: rtl/fifo_frame_ctrl_if.sv
// fifo_frame_ctrl_if: control and handshake bundle for fifo_frame_ctrl.
//   start_i/abort_i/frame_len_i : frame control from the control block
//   adc_ready_i                 : ADC sample strobe
//   fir_ready_i                 : FIR back-pressure
//   full_i/empty_i              : sample buffer flags
//   wr_en_o/rd_en_o             : sample buffer enables
//   fir_valid_o                 : buffer output data valid for the FIR
//   busy_o/done_o/overflow_o    : status
//   fill_cnt_o                  : samples written in the current frame
// The slave modport is the controller's view; the master modport drives it.
interface fifo_frame_ctrl_if #(
  parameter int unsigned CNT_W = 11
);
  logic             start_i;
  logic             abort_i;
  logic [CNT_W-1:0] frame_len_i;
  logic             adc_ready_i;
  logic             fir_ready_i;
  logic             full_i;
  logic             empty_i;
  logic             wr_en_o;
  logic             rd_en_o;
  logic             fir_valid_o;
  logic             busy_o;
  logic             done_o;
  logic             overflow_o;
  logic [CNT_W-1:0] fill_cnt_o;

  modport slave (
    input  start_i, abort_i, frame_len_i, adc_ready_i, fir_ready_i, full_i, empty_i,
    output wr_en_o, rd_en_o, fir_valid_o, busy_o, done_o, overflow_o, fill_cnt_o
  );

  modport master (
    output start_i, abort_i, frame_len_i, adc_ready_i, fir_ready_i, full_i, empty_i,
    input  wr_en_o, rd_en_o, fir_valid_o, busy_o, done_o, overflow_o, fill_cnt_o
  );
endinterface

// File: rtl/fifo_frame_ctrl.sv
// fifo_frame_ctrl: sequences the ADC -> sample buffer -> FIR path.
// Fills the buffer with len samples, drains them to the FIR under back-pressure,
// waits for the read-latency pipeline to empty and pulses done_o.
// Ports:
//   clk_i  : system clock
//   rst_i  : asynchronous active-low reset
//   bus    : fifo_frame_ctrl_if.slave (control, buffer flags/enables, FIR strobes, status)
// Optional feature: define FRAME_AUTO_RESTART_EN to make DONE restart FILL with the
// same latched length (continuous streaming until abort).
module fifo_frame_ctrl #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned CNT_W  = 11,
  parameter int unsigned RD_LAT = 1
) (
  input logic              clk_i,
  input logic              rst_i,
  fifo_frame_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] LenMax = CNT_W'(DEPTH);

  typedef enum logic [2:0] {StIdle, StFill, StDrain, StFlush, StDone} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic              overflow_q, overflow_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic              wr_en, rd_en;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    rd_en      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start_i && (bus.frame_len_i != '0)) begin
          state_d    = StFill;
          len_d      = (bus.frame_len_i > LenMax) ? LenMax : bus.frame_len_i;
          wr_cnt_d   = '0;
          rd_cnt_d   = '0;
          overflow_d = 1'b0;
        end
      end
      StFill: begin
        wr_en = bus.adc_ready_i && !bus.full_i && (wr_cnt_q < len_q);
        if (bus.adc_ready_i && bus.full_i && (wr_cnt_q < len_q)) overflow_d = 1'b1;
        if (wr_en) wr_cnt_d = wr_cnt_q + 1'b1;
        // Leave on the edge that commits the last write.
        if (wr_cnt_d == len_q) state_d = StDrain;
      end
      StDrain: begin
        rd_en = bus.fir_ready_i && !bus.empty_i && (rd_cnt_q < len_q);
        if (rd_en) rd_cnt_d = rd_cnt_q + 1'b1;
        if (rd_cnt_q == len_q) state_d = StFlush;
      end
      StFlush: begin
        if (vld_q == '0) state_d = StDone;
      end
      StDone: begin
`ifdef FRAME_AUTO_RESTART_EN
        state_d  = StFill;
        wr_cnt_d = '0;
        rd_cnt_d = '0;
`else
        state_d  = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over everything, including a same-cycle start; counters freeze.
    if (bus.abort_i) begin
      state_d  = StIdle;
      len_d    = len_q;
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
      wr_en    = 1'b0;
      rd_en    = 1'b0;
    end
  end

  // Read-latency pipeline: fir_valid_o is rd_en delayed by RD_LAT cycles.
  always_comb begin
    vld_d = (vld_q << 1) | RD_LAT'(rd_en);
    if (bus.abort_i) vld_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= StIdle;
      len_q      <= '0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      overflow_q <= 1'b0;
      vld_q      <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      overflow_q <= overflow_d;
      vld_q      <= vld_d;
    end
  end

  assign bus.wr_en_o     = wr_en;
  assign bus.rd_en_o     = rd_en;
  assign bus.fir_valid_o = vld_q[RD_LAT-1];
  assign bus.busy_o      = (state_q != StIdle);
  assign bus.done_o      = (state_q == StDone);
  assign bus.overflow_o  = overflow_q;
  assign bus.fill_cnt_o  = wr_cnt_q;

endmodule

// File: tb/tb_fifo_frame_ctrl.sv
// Self-checking bench for fifo_frame_ctrl: table of frame vectors, a read->valid
// scoreboard, and hand-written overflow / reset / auto-restart sequences.
module tb_fifo_frame_ctrl;
  localparam int DEPTH  = 1024;
  localparam int CNT_W  = 11;
  localparam int RD_LAT = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_frame_ctrl_if #(.CNT_W(CNT_W)) bus ();

  fifo_frame_ctrl #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus  (bus)
  );

  // Behavioural buffer occupancy for the full/empty flags.
  int   occ        = 0;
  logic force_full = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)           occ <= 0;
    else if (bus.abort_i) occ <= 0;
    else                  occ <= occ + int'(bus.wr_en_o) - int'(bus.rd_en_o);
  end
  assign bus.full_i  = force_full | (occ >= DEPTH);
  assign bus.empty_i = (occ == 0);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor and scoreboard: each read pushes the cycle its valid must appear in.
  int n_wr = 0, n_rd = 0, n_vld = 0, n_done = 0, last_done_cyc = 0;
  int exp_q[$];
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (bus.wr_en_o) begin
        n_wr <= n_wr + 1;
        check("wr_while_full", int'(bus.full_i), 0);
      end
      if (bus.rd_en_o) begin
        n_rd <= n_rd + 1;
        check("rd_without_fir_ready", int'(bus.fir_ready_i), 1);
        check("rd_while_empty", int'(bus.empty_i), 0);
        exp_q.push_back(cyc + RD_LAT);
      end
      if (bus.fir_valid_o) begin
        n_vld <= n_vld + 1;
        if (exp_q.size() == 0) check("valid_unexpected_qsize", exp_q.size(), 1);
        else check("valid_latency_cycle", cyc, exp_q.pop_front());
      end
      if (bus.done_o) begin
        n_done        <= n_done + 1;
        last_done_cyc <= cyc;
      end
    end
  end

  typedef struct {
    int len;
    bit toggle;
    bit same_abort;
    int abort_at;
    int exp_busy1;
    int exp_wr;
    int exp_rd;
    int exp_done;
    int exp_lat;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.busy_o && n < 3000) begin
      tick();
      n++;
    end
    check(name, int'(bus.busy_o), 0);
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    int wr0 = n_wr, rd0 = n_rd, vld0 = n_vld, done0 = n_done;
    int start_cyc;
    int n = 1;
    bit fin = 1'b0;
    bit did_abort;
    tick();
    bus.frame_len_i = CNT_W'(v.len);
    bus.start_i     = 1'b1;
    bus.abort_i     = v.same_abort;
    start_cyc       = cyc;
    tick();
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    check($sformatf("v%0d_busy_after_start", idx), int'(bus.busy_o), v.exp_busy1);
    while (!fin && n < 3000) begin
      bus.abort_i = 1'b0;
      if (v.toggle) bus.fir_ready_i = ~bus.fir_ready_i;
      if (!bus.busy_o && n >= 3) begin
        fin = 1'b1;
      end else begin
        if (v.abort_at != 0 && bus.busy_o && int'(bus.fill_cnt_o) == v.abort_at)
          bus.abort_i = 1'b1;
`ifdef FRAME_AUTO_RESTART_EN
        if (bus.done_o) bus.abort_i = 1'b1;
`endif
        did_abort = bus.abort_i;
        tick();
        n++;
        if (did_abort) check($sformatf("v%0d_abort_idle", idx), int'(bus.busy_o), 0);
      end
    end
    bus.abort_i     = 1'b0;
    bus.fir_ready_i = 1'b1;
    check($sformatf("v%0d_finished_in_budget", idx), int'(fin), 1);
    check($sformatf("v%0d_writes", idx), n_wr - wr0, v.exp_wr);
    check($sformatf("v%0d_reads", idx), n_rd - rd0, v.exp_rd);
    check($sformatf("v%0d_valids", idx), n_vld - vld0, v.exp_rd);
    check($sformatf("v%0d_done_pulses", idx), n_done - done0, v.exp_done);
    check($sformatf("v%0d_scoreboard_empty", idx), exp_q.size(), 0);
    if (v.exp_lat != 0)
      check($sformatf("v%0d_latency", idx), last_done_cyc - start_cyc, v.exp_lat);
    if (v.exp_wr != 0)
      check($sformatf("v%0d_fill_cnt", idx), int'(bus.fill_cnt_o), v.exp_wr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    int d0;
    //            len   tog same ab_at busy wr    rd    done lat
    vecs[0] = '{  4,    0,  0,   0,    1,   4,    4,    1,   11};
    vecs[1] = '{  8,    1,  0,   0,    1,   8,    8,    1,   0};
    vecs[2] = '{  1,    0,  0,   0,    1,   1,    1,    1,   5};
    vecs[3] = '{  0,    0,  0,   0,    0,   0,    0,    0,   0};
    vecs[4] = '{  2000, 0,  0,   0,    1,   1024, 1024, 1,   2051};
    vecs[5] = '{  5,    0,  1,   0,    0,   0,    0,    0,   0};
    vecs[6] = '{  16,   0,  0,   5,    1,   5,    0,    0,   0};
    vecs[7] = '{  4,    0,  0,   0,    1,   4,    4,    1,   11};

    bus.start_i     = 1'b0;
    bus.abort_i     = 1'b0;
    bus.frame_len_i = '0;
    bus.adc_ready_i = 1'b0;
    bus.fir_ready_i = 1'b0;

    // Reset state.
    #12;
    check("rst_wr_en", int'(bus.wr_en_o), 0);
    check("rst_rd_en", int'(bus.rd_en_o), 0);
    check("rst_fir_valid", int'(bus.fir_valid_o), 0);
    check("rst_busy", int'(bus.busy_o), 0);
    check("rst_done", int'(bus.done_o), 0);
    check("rst_overflow", int'(bus.overflow_o), 0);
    check("rst_fill_cnt", int'(bus.fill_cnt_o), 0);
    tick();
    rst_n           = 1'b1;
    bus.adc_ready_i = 1'b1;
    bus.fir_ready_i = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 8; i++) run_frame(vecs[i], i);

    // Overflow: buffer reports full after 10 writes.
    tick();
    bus.frame_len_i = CNT_W'(DEPTH);
    bus.start_i     = 1'b1;
    tick();
    bus.start_i = 1'b0;
    k = 0;
    while (int'(bus.fill_cnt_o) != 10 && k < 100) begin
      tick();
      k++;
    end
    check("ovf_fill_reached_10", int'(bus.fill_cnt_o), 10);
    force_full = 1'b1;
    #1;
    check("ovf_wr_en_low_when_full", int'(bus.wr_en_o), 0);
    check("ovf_not_yet_set", int'(bus.overflow_o), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ovf_fill_holds", int'(bus.fill_cnt_o), 10);
      check("ovf_wr_en_low", int'(bus.wr_en_o), 0);
      check("ovf_sticky", int'(bus.overflow_o), 1);
    end
    force_full  = 1'b0;
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
    check("ovf_abort_idle", int'(bus.busy_o), 0);
    check("ovf_kept_after_abort", int'(bus.overflow_o), 1);
    bus.frame_len_i = CNT_W'(4);
    bus.start_i     = 1'b1;
    tick();
    bus.start_i = 1'b0;
    check("ovf_cleared_by_start", int'(bus.overflow_o), 0);
    check("ovf_restart_busy", int'(bus.busy_o), 1);
`ifdef FRAME_AUTO_RESTART_EN
    k = 0;
    while (!bus.done_o && k < 100) begin
      tick();
      k++;
    end
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
`endif
    wait_idle("ovf_restart_frame_idle");

    // Asynchronous reset during DRAIN.
    tick();
    bus.frame_len_i = CNT_W'(8);
    bus.start_i     = 1'b1;
    tick();
    bus.start_i = 1'b0;
    k = 0;
    while (!bus.rd_en_o && k < 100) begin
      tick();
      k++;
    end
    check("rst_mid_reached_drain", int'(bus.rd_en_o), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_wr_en", int'(bus.wr_en_o), 0);
    check("rst_mid_rd_en", int'(bus.rd_en_o), 0);
    check("rst_mid_fir_valid", int'(bus.fir_valid_o), 0);
    check("rst_mid_busy", int'(bus.busy_o), 0);
    check("rst_mid_done", int'(bus.done_o), 0);
    check("rst_mid_fill_cnt", int'(bus.fill_cnt_o), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_mid_stays_idle", int'(bus.busy_o), 0);

`ifdef FRAME_AUTO_RESTART_EN
    // Continuous streaming: len 3 gives a 9-cycle frame period.
    d0 = n_done;
    tick();
    bus.frame_len_i = CNT_W'(3);
    bus.start_i     = 1'b1;
    tick();
    bus.start_i = 1'b0;
    repeat (44) tick();
    check("auto_still_busy", int'(bus.busy_o), 1);
    check("auto_done_per_frame", n_done - d0, 4);
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
    check("auto_abort_idle", int'(bus.busy_o), 0);
`else
    d0 = n_done;
    tick();
    check("no_spurious_done", n_done - d0, 0);
`endif

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
